// File: rtl/sisc_pkg.sv
// Shared types and constants for the sisc instruction fetch unit.
package sisc_pkg;

    localparam int              IR_W   = 32;
    localparam logic [IR_W-1:0] NOP    = 32'h0;
    localparam int              AW_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read port: req/ack handshake with a word address and 32-bit data.
interface sisc_ifetch_if
    import sisc_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic            req;
    logic [AW-1:0]   addr;
    logic            ack;
    logic [IR_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/sisc_ifetch_pbuf.sv
// One-entry prefetch buffer plus the flag that marks an in-flight read as stale.
// Only present in builds with IFETCH_PREFETCH_EN defined.
`ifdef IFETCH_PREFETCH_EN
module sisc_ifetch_pbuf
    import sisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fill_i,
    input  logic [IR_W-1:0] fill_data_i,
    input  logic            clr_i,
    input  logic            drop_set_i,
    input  logic            drop_clr_i,
    output logic            full_o,
    output logic [IR_W-1:0] data_o,
    output logic            drop_o
);
    logic            full_q;
    logic [IR_W-1:0] data_q;
    logic            drop_q;

    // Buffer slot: any retire empties it (consumed or discarded), otherwise a fill loads it.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            full_q <= 1'b0;
            data_q <= NOP;
            drop_q <= 1'b0;
        end else begin
            if (clr_i) begin
                full_q <= 1'b0;
            end else if (fill_i) begin
                full_q <= 1'b1;
                data_q <= fill_data_i;
            end
            if (drop_set_i)      drop_q <= 1'b1;
            else if (drop_clr_i) drop_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign drop_o = drop_q;
endmodule
`endif

// File: rtl/sisc_ifetch.sv
// sisc instruction fetch: owns the PC, reads imem over req/ack, presents ir to the core
// until retired, applies branch redirects and halt.
// Build option: IFETCH_PREFETCH_EN adds a one-entry prefetch buffer (1 instr/cycle).
module sisc_ifetch
    import sisc_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst_f,
    sisc_ifetch_if.master   imem,
    output logic [IR_W-1:0] ir,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic            br_taken,
    input  logic [AW-1:0]   br_target,
    input  logic            halt,
    output logic [AW-1:0]   pc
);
    fetch_state_e    state_q;
    logic [AW-1:0]   pc_q, pc_next_q, addr_q;
    logic [IR_W-1:0] ir_q;
    logic            ir_valid_q, req_q;

    logic            ack, retire;
    logic [AW-1:0]   seq_pc;

    // An ack only counts against our own outstanding request.
    assign ack    = req_q & imem.ack;
    assign retire = ir_valid_q & ir_ready;
    assign seq_pc = pc_q + AW'(1);

`ifdef IFETCH_PREFETCH_EN
    logic            pf_full, pf_drop, pf_hit;
    logic [IR_W-1:0] pf_data, pf_word;
    logic            in_valid;

    assign in_valid = (state_q == S_VALID);
    // Next sequential word is available either from the buffer or arriving right now.
    assign pf_hit   = pf_full | ack;
    assign pf_word  = pf_full ? pf_data : imem.rdata;

    sisc_ifetch_pbuf u_pbuf (
        .clk         (clk),
        .rst_f       (rst_f),
        .fill_i      (in_valid & ack & ~retire),
        .fill_data_i (imem.rdata),
        .clr_i       (in_valid & retire),
        .drop_set_i  (in_valid & retire & (halt | br_taken) & req_q & ~imem.ack),
        .drop_clr_i  (pf_drop & ack),
        .full_o      (pf_full),
        .data_o      (pf_data),
        .drop_o      (pf_drop)
    );

    // Fetch FSM with prefetch: a redirect waits for any in-flight read to land (and drops it).
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_next_q  <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= pc_next_q;
                end
                S_FETCH: begin
                    if (ack) begin
                        if (pf_drop) begin
                            // stale prefetch landed; the redirect read starts now
                            addr_q <= pc_next_q;
                        end else begin
                            ir_q       <= imem.rdata;
                            pc_q       <= pc_next_q;
                            ir_valid_q <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (retire) begin
                        if (halt) begin
                            ir_valid_q <= 1'b0;
                            req_q      <= req_q & ~imem.ack;
                            state_q    <= S_HALT;
                        end else if (br_taken) begin
                            ir_valid_q <= 1'b0;
                            pc_next_q  <= br_target;
                            state_q    <= S_FETCH;
                            if (!(req_q && !imem.ack)) begin
                                req_q  <= 1'b1;
                                addr_q <= br_target;
                            end
                        end else if (pf_hit) begin
                            ir_q   <= pf_word;
                            pc_q   <= seq_pc;
                            req_q  <= 1'b1;
                            addr_q <= pc_q + AW'(2);
                        end else begin
                            // prefetch (if any) is already for seq_pc; S_FETCH picks it up
                            ir_valid_q <= 1'b0;
                            pc_next_q  <= seq_pc;
                            req_q      <= 1'b1;
                            addr_q     <= seq_pc;
                            state_q    <= S_FETCH;
                        end
                    end else if (ack) begin
                        req_q <= 1'b0;
                    end else if (!req_q && !pf_full) begin
                        req_q  <= 1'b1;
                        addr_q <= seq_pc;
                    end
                end
                S_HALT: begin
                    if (ack) req_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    logic [AW-1:0] redir_pc;
    assign redir_pc = br_taken ? br_target : seq_pc;

    // Fetch FSM without prefetch: one read per instruction, issued after retire.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_next_q  <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= pc_next_q;
                end
                S_FETCH: begin
                    if (ack) begin
                        ir_q       <= imem.rdata;
                        pc_q       <= pc_next_q;
                        ir_valid_q <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (retire) begin
                        ir_valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= S_HALT;
                        end else begin
                            pc_next_q <= redir_pc;
                            addr_q    <= redir_pc;
                            req_q     <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_HALT:  ;
                default: state_q <= S_IDLE;
            endcase
        end
    end
`endif

    assign imem.req  = req_q;
    assign imem.addr = addr_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc        = pc_q;
endmodule
